ras_ctrl: RTL and testbench

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/sys_defs.sv | 17 +
 rtl/ras_ctrl_predecode.sv | 27 ++
 rtl/ras_ctrl.sv | 130 +++++++++++++
 tb/tb_ras_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared sizing and Alpha control-flow opcode constants for the RAS controller.
package sys_defs;

    localparam int RAS_SIZE = 8;
    localparam int DEPTH_W  = $clog2(RAS_SIZE) + 1;

    localparam logic [5:0] OP_BSR = 6'h34;
    localparam logic [5:0] OP_JSR = 6'h1A;

    typedef enum logic [1:0] {
        HINT_JMP  = 2'b00,
        HINT_JSR  = 2'b01,
        HINT_RET  = 2'b10,
        HINT_CORO = 2'b11
    } jsr_hint_e;

endpackage

// File: rtl/ras_ctrl_predecode.sv
// Combinational call/return classifier for Alpha BSR and JSR-group instructions.
module ras_predecode
    import sys_defs::*;
(
    input  logic [31:0] inst,
    output logic        is_call,
    output logic        is_return
);

    logic [5:0] opc;
    jsr_hint_e  hint;

    assign opc  = inst[31:26];
    assign hint = jsr_hint_e'(inst[15:14]);

    always_comb begin
        is_call   = 1'b0;
        is_return = 1'b0;
        if (opc == OP_BSR) begin
            is_call = 1'b1;
        end else if (opc == OP_JSR) begin
            is_call   = hint inside {HINT_JSR, HINT_CORO};
            is_return = hint inside {HINT_RET, HINT_CORO};
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// Fetch-side RAS controller: stage register, push/pop issue, return prediction.
// Optional statistics counters are enabled with RAS_CTRL_STATS_EN.
module ras_ctrl
    import sys_defs::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               if_valid,
    input  logic [31:0]        if_pc,
    input  logic [31:0]        if_inst,
    input  logic               stall,
    input  logic               squash,
    input  logic [31:0]        ras_next_pc,
    input  logic               ras_valid,
    output logic               ras_write_en,
    output logic               ras_clear_en,
    output logic [31:0]        ras_current_pc,
    output logic               out_valid,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_inst,
    output logic               pred_valid,
    output logic [31:0]        pred_target,
`ifdef RAS_CTRL_STATS_EN
    output logic [31:0]        stat_calls,
    output logic [31:0]        stat_returns,
    output logic [31:0]        stat_ret_pred,
`endif
    output logic [DEPTH_W-1:0] depth
);

    logic               valid_q, valid_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic               call_q, call_d;
    logic               ret_q, ret_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               pd_call, pd_ret;
    logic               fire;

    ras_predecode u_predecode (
        .inst      (if_inst),
        .is_call   (pd_call),
        .is_return (pd_ret)
    );

    assign fire = valid_q & ~stall & ~squash;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        call_d  = call_q;
        ret_d   = ret_q;
        if (squash) begin
            valid_d = 1'b0;
            call_d  = 1'b0;
            ret_d   = 1'b0;
        end else if (!stall) begin
            valid_d = if_valid;
            pc_d    = if_pc;
            inst_d  = if_inst;
            call_d  = pd_call;
            ret_d   = pd_ret;
        end
    end

    // A coroutine (push and pop together) replaces the top: occupancy unchanged.
    always_comb begin
        depth_d = depth_q;
        if (fire && call_q && !ret_q) begin
            if (depth_q != DEPTH_W'(RAS_SIZE))
                depth_d = depth_q + 1'b1;
        end else if (fire && ret_q && !call_q) begin
            if (depth_q != '0)
                depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            call_q  <= 1'b0;
            ret_q   <= 1'b0;
            depth_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            call_q  <= call_d;
            ret_q   <= ret_d;
            depth_q <= depth_d;
        end
    end

    assign ras_write_en   = fire & call_q;
    assign ras_clear_en   = fire & ret_q;
    assign ras_current_pc = pc_q;
    assign out_valid      = valid_q;
    assign out_pc         = pc_q;
    assign out_inst       = inst_q;
    assign pred_valid     = valid_q & ret_q & ras_valid;
    assign pred_target    = ras_next_pc;
    assign depth          = depth_q;

`ifdef RAS_CTRL_STATS_EN
    logic [31:0] calls_q, returns_q, pred_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            calls_q   <= '0;
            returns_q <= '0;
            pred_q    <= '0;
        end else begin
            if (fire && call_q && calls_q != '1)
                calls_q <= calls_q + 1'b1;
            if (fire && ret_q && returns_q != '1)
                returns_q <= returns_q + 1'b1;
            if (fire && pred_valid && pred_q != '1)
                pred_q <= pred_q + 1'b1;
        end
    end

    assign stat_calls    = calls_q;
    assign stat_returns  = returns_q;
    assign stat_ret_pred = pred_q;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Randomized bench for ras_ctrl against a behavioural model of the stage and shadow RAS depth.
module tb_ras_ctrl;

    localparam int RSZ = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;
    logic        stall, squash;
    logic [31:0] ras_next_pc;
    logic        ras_valid;
    logic        ras_write_en, ras_clear_en;
    logic [31:0] ras_current_pc;
    logic        out_valid;
    logic [31:0] out_pc, out_inst;
    logic        pred_valid;
    logic [31:0] pred_target;
    logic [3:0]  depth;
`ifdef RAS_CTRL_STATS_EN
    logic [31:0] stat_calls, stat_returns, stat_ret_pred;
`endif

    always #5 clock = ~clock;

    ras_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .stall          (stall),
        .squash         (squash),
        .ras_next_pc    (ras_next_pc),
        .ras_valid      (ras_valid),
        .ras_write_en   (ras_write_en),
        .ras_clear_en   (ras_clear_en),
        .ras_current_pc (ras_current_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .pred_valid     (pred_valid),
        .pred_target    (pred_target),
`ifdef RAS_CTRL_STATS_EN
        .stat_calls     (stat_calls),
        .stat_returns   (stat_returns),
        .stat_ret_pred  (stat_ret_pred),
`endif
        .depth          (depth)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model state: the instruction held for decode and the shadow occupancy.
    bit          m_valid;
    logic [31:0] m_pc, m_inst;
    int          m_depth;
    int          n_push;

    function automatic bit is_call(input logic [31:0] i);
        int op = int'(i[31:26]);
        int h  = int'(i[15:14]);
        return (op == 'h34) || (op == 'h1A && (h == 1 || h == 3));
    endfunction

    function automatic bit is_ret(input logic [31:0] i);
        int op = int'(i[31:26]);
        int h  = int'(i[15:14]);
        return (op == 'h1A) && (h == 2 || h == 3);
    endfunction

    function automatic logic [31:0] mk(input int kind);
        logic [31:0] r = $urandom;
        case (kind)
            0: r[31:26] = 6'h34;
            1: begin r[31:26] = 6'h1A; r[15:14] = 2'b01; end
            2: begin r[31:26] = 6'h1A; r[15:14] = 2'b10; end
            3: begin r[31:26] = 6'h1A; r[15:14] = 2'b11; end
            4: begin r[31:26] = 6'h1A; r[15:14] = 2'b00; end
            default: r[31:26] = 6'h10;
        endcase
        return r;
    endfunction

    task automatic step(input bit rst, input bit v, input logic [31:0] pc,
                        input logic [31:0] inst, input bit st, input bit sq,
                        input bit rv, input logic [31:0] rnpc);
        bit fire, c, r;
        @(negedge clock);
        reset = rst; if_valid = v; if_pc = pc; if_inst = inst;
        stall = st; squash = sq; ras_valid = rv; ras_next_pc = rnpc;
        #1;
        fire = m_valid && !st && !sq;
        c = m_valid && is_call(m_inst);
        r = m_valid && is_ret(m_inst);
        check("write_en", 32'(ras_write_en), 32'(fire && c));
        check("clear_en", 32'(ras_clear_en), 32'(fire && r));
        check("cur_pc", ras_current_pc, m_pc);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_pc", out_pc, m_pc);
        check("out_inst", out_inst, m_inst);
        check("pred_valid", 32'(pred_valid), 32'(r && rv));
        check("pred_target", pred_target, rnpc);
        check("depth", 32'(depth), 32'(m_depth));
        if (fire && c) n_push++;
        @(posedge clock);
        if (rst) begin
            m_valid = 0; m_pc = 0; m_inst = 0; m_depth = 0;
        end else begin
            if (fire && c && !r) m_depth = (m_depth < RSZ) ? m_depth + 1 : RSZ;
            if (fire && r && !c) m_depth = (m_depth > 0) ? m_depth - 1 : 0;
            if (sq) m_valid = 0;
            else if (!st) begin m_valid = v; m_pc = pc; m_inst = inst; end
        end
    endtask

    task automatic idle(input bit rst);
        step(rst, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_valid = 0; m_pc = 0; m_inst = 0; m_depth = 0; n_push = 0;
        idle(1);
        idle(1);
        idle(0);
        // BSR at 0x100, then RET predicted to 0x104.
        step(0, 1, 32'h100, mk(0), 0, 0, 0, 0);
        step(0, 1, 32'h200, mk(2), 0, 0, 1, 32'h104);
        step(0, 0, 0, 0, 0, 0, 1, 32'h104);
        idle(0);
        check("ret_depth0", 32'(depth), 32'd0);
        // Three calls then a coroutine.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h300 + 4 * i, mk(1), 0, 0, 0, 0);
        step(0, 1, 32'h400, mk(3), 0, 0, 1, 32'h30c);
        step(0, 0, 0, 0, 0, 0, 1, 32'h30c);
        idle(0);
        check("coro_depth3", 32'(depth), 32'd3);
        // Call held under stall for 3 cycles, then released.
        n_push = 0;
        step(0, 1, 32'h500, mk(0), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h600, mk(4), 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        check("stall_pushes", 32'(n_push), 32'd1);
        // Squash of a held call, then drain to empty and pop at depth 0.
        step(0, 1, 32'h700, mk(0), 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 32'h800, mk(2), 0, 0, 0, 0);
        idle(0);
        check("empty_depth", 32'(depth), 32'd0);
        // Nine calls saturate at 8; reset mid-stall.
        for (int i = 0; i < 10; i++) step(0, 1, 32'h900 + 4 * i, mk(0), 0, 0, 0, 0);
        check("sat_depth", 32'(depth), 32'(RSZ));
        step(0, 1, 32'hA00, mk(0), 1, 0, 0, 0);
        step(1, 1, 32'hA04, mk(0), 1, 1, 0, 0);
        idle(0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 80),
                 $urandom & 32'hFFFF_FFFC, mk($urandom_range(6)),
                 ($urandom_range(99) < 25), ($urandom_range(99) < 8),
                 $urandom_range(1), $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
